// File: rtl/posit_extract_pkg.sv
`default_nettype none
// ============================================================================
// Package  : posit_extract_pkg
// Purpose  : Shared widths, pattern constants and field bundle for posit8 decode
// Revision : 1.0
// ============================================================================
package posit_extract_pkg;

    localparam int N          = 8;
    localparam int ES_DEFAULT = 2;
    localparam int ES_MAX     = 3;
    localparam int MW         = N - 2;

    function automatic int scale_w(input int es);
        return 3 + es + 1;
    endfunction

    // The bundle carries the widest scale so one type serves every legal ES.
    localparam int SCALE_W_MAX = scale_w(ES_MAX);

    localparam logic [N-1:0] c_zero_pattern = 8'h00;
    localparam logic [N-1:0] c_nar_pattern  = 8'h80;

    typedef struct packed {
        logic                          sign;
        logic                          zero;
        logic                          nar;
        logic signed [SCALE_W_MAX-1:0] scale;
        logic [MW-1:0]                 mant;
    } posit_fields_t;

endpackage
`default_nettype wire

// File: rtl/fulladder_8bit.sv
`default_nettype none
// ============================================================================
// Module   : fulladder_8bit
// Purpose  : 8-bit ripple-carry adder, s = a + b + ci
// Revision : 1.0
// ============================================================================
module fulladder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);

    logic [8:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign co = w_c[8];

endmodule
`default_nettype wire

// File: rtl/posit8_regime_decode.sv
`default_nettype none
// ============================================================================
// Module   : posit8_regime_decode
// Purpose  : Combinational split of a posit magnitude into scale and mantissa
// Revision : 1.0
// ============================================================================
module posit8_regime_decode
    import posit_extract_pkg::*;
#(
    parameter int ES = ES_DEFAULT
) (
    input  logic [N-2:0]  body,
    input  logic          sign,
    input  logic          zero,
    input  logic          nar,
    output posit_fields_t fields
);

    logic                          w_r0;
    logic [2:0]                    w_run;
    logic                          w_stop;
    logic [4:0]                    w_rem;
    logic [2:0]                    w_e;
    logic [4:0]                    w_frac;
    logic signed [SCALE_W_MAX-1:0] w_run_s;
    logic signed [SCALE_W_MAX-1:0] w_k;
    logic signed [SCALE_W_MAX-1:0] w_scale;

    assign w_r0 = body[6];

    always_comb begin
        w_run  = 3'd1;
        w_stop = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            if (!w_stop && (body[i] == w_r0)) begin
                w_run = w_run + 3'd1;
            end else begin
                w_stop = 1'b1;
            end
        end
    end

    // Bits after run+terminator, left-aligned; a full-length run leaves nothing.
    assign w_rem = 5'(body[4:0] << (w_run - 3'd1));

    if (ES > 0) begin : g_exp
        assign w_e = 3'(w_rem[4 -: ES]);
    end else begin : g_no_exp
        assign w_e = 3'd0;
    end

    assign w_frac  = 5'(w_rem << ES);
    assign w_run_s = signed'(SCALE_W_MAX'(w_run));
    assign w_k     = w_r0 ? (w_run_s - signed'(SCALE_W_MAX'(1))) : -w_run_s;
    assign w_scale = (w_k <<< ES) + signed'(SCALE_W_MAX'(w_e));

    always_comb begin
        fields.sign  = sign;
        fields.zero  = zero;
        fields.nar   = nar;
        fields.scale = (zero || nar) ? '0 : w_scale;
        fields.mant  = (zero || nar) ? '0 : {1'b1, w_frac};
    end

endmodule
`default_nettype wire

// File: rtl/posit8_field_extract.sv
`default_nettype none
// ============================================================================
// Module   : posit8_field_extract
// Purpose  : Two-stage valid/ready posit<8,ES> decoder: sign, flags, scale, mantissa
// Revision : 1.0
// ============================================================================
module posit8_field_extract
    import posit_extract_pkg::*;
#(
    parameter  int ES      = ES_DEFAULT,
    localparam int SCALE_W = scale_w(ES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N-1:0]              in_posit,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_sign,
    output logic                      out_zero,
    output logic                      out_nar,
    output logic signed [SCALE_W-1:0] out_scale,
    output logic [MW-1:0]             out_mant
);

    logic          w_s1_take;
    logic          w_s2_take;
    logic [N-1:0]  w_neg;
    logic          w_neg_co;
    logic          w_adder_unused;
    logic [N-2:0]  w_abs_body;
    posit_fields_t w_fields;

    logic          r_s1_valid;
    logic          r_s1_sign;
    logic          r_s1_zero;
    logic          r_s1_nar;
    logic [N-2:0]  r_s1_body;
    logic          r_s2_valid;
    posit_fields_t r_out;

    assign w_s2_take = !r_s2_valid || out_ready;
    assign w_s1_take = !r_s1_valid || w_s2_take;
    assign in_ready  = w_s1_take;

    fulladder_8bit u_negate (
        .a  (~in_posit),
        .b  ({N{1'b0}}),
        .ci (1'b1),
        .s  (w_neg),
        .co (w_neg_co)
    );

    // Only NaR has a magnitude with bit 7 set, and NaR is flagged separately.
    assign w_adder_unused = ^{w_neg[N-1], w_neg_co};
    assign w_abs_body     = in_posit[N-1] ? w_neg[N-2:0] : in_posit[N-2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_nar   <= 1'b0;
            r_s1_body  <= '0;
        end else if (w_s1_take) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign <= in_posit[N-1];
                r_s1_zero <= (in_posit == c_zero_pattern);
                r_s1_nar  <= (in_posit == c_nar_pattern);
                r_s1_body <= w_abs_body;
            end
        end
    end

    posit8_regime_decode #(
        .ES (ES)
    ) u_regime_decode (
        .body   (r_s1_body),
        .sign   (r_s1_sign),
        .zero   (r_s1_zero),
        .nar    (r_s1_nar),
        .fields (w_fields)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_out      <= '0;
        end else if (w_s2_take) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out <= w_fields;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_sign  = r_out.sign;
    assign out_zero  = r_out.zero;
    assign out_nar   = r_out.nar;
    assign out_scale = r_out.scale[SCALE_W-1:0];
    assign out_mant  = r_out.mant;

    // Scale range always fits SCALE_W, so the extra bundle bits are redundant.
    if (SCALE_W < SCALE_W_MAX) begin : g_scale_trim
        logic w_scale_hi_unused;
        assign w_scale_hi_unused = ^r_out.scale[SCALE_W_MAX-1:SCALE_W];
    end

endmodule
`default_nettype wire
